// File: rtl/mux_somador_registrador_pkg.sv
// Shared width default and mux-select encoding for the mux/adder/register slice.
package mux_somador_registrador_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    SEL_C = 1'b0,
    SEL_B = 1'b1
  } sel_e;

endpackage

// File: rtl/mux_somador_registrador_somador_mux.sv
// Combinational 2:1 mux (S=1 -> B, S=0 -> C) feeding an unsigned adder with A.
// The sum is formed one bit wider than the operands so the carry is kept.
module somador_mux
  import mux_somador_registrador_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic             S,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH-1:0] sel_s;
  logic [WIDTH:0]   sum_full_s;

  // Operand select; an unknown select falls back to C.
  always_comb begin
    sel_s = C;
    case (sel_e'(S))
      SEL_B:   sel_s = B;
      SEL_C:   sel_s = C;
      default: sel_s = C;
    endcase
  end

  // Widened add so the top bit carries out.
  always_comb begin
    sum_full_s = {1'b0, A} + {1'b0, sel_s};
  end

  assign sum   = sum_full_s[WIDTH-1:0];
  assign carry = sum_full_s[WIDTH];

endmodule

// File: rtl/mux_somador_registrador.sv
// Mux-then-add datapath stage with an enabled, asynchronously reset result register.
// Define MUX_SOMADOR_REGISTRADOR_COUT_EN to add the registered carry output COUT.
module mux_somador_registrador
  import mux_somador_registrador_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic             S,
  input  logic             ENABLE,
`ifdef MUX_SOMADOR_REGISTRADOR_COUT_EN
  output logic             COUT,
`endif
  output logic [WIDTH-1:0] RES
);

  logic [WIDTH-1:0] sum_s;
  logic             carry_s;
  logic [WIDTH-1:0] res_r;

  somador_mux #(
    .WIDTH (WIDTH)
  ) u_somador_mux (
    .A     (A),
    .B     (B),
    .C     (C),
    .S     (S),
    .sum   (sum_s),
    .carry (carry_s)
  );

  // Result register: reset wins over everything, otherwise load only when enabled.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      res_r <= '0;
    end else if (ENABLE) begin
      res_r <= sum_s;
    end
  end

  assign RES = res_r;

`ifdef MUX_SOMADOR_REGISTRADOR_COUT_EN
  logic cout_r;

  // Carry register, loaded under the same rules as the result.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cout_r <= 1'b0;
    end else if (ENABLE) begin
      cout_r <= carry_s;
    end
  end

  assign COUT = cout_r;
`else
  logic unused_carry_s;
  assign unused_carry_s = carry_s;
`endif

endmodule

// File: tb/tb_mux_somador_registrador.sv
// Self-checking bench: directed scenarios plus randomized traffic against a plain-arithmetic model.
// Build with MUX_SOMADOR_REGISTRADOR_COUT_EN defined to also check COUT.
module tb_mux_somador_registrador;
  import mux_somador_registrador_pkg::*;

  localparam int W   = DEFAULT_WIDTH;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b, c, res;
  logic         s, en;
`ifdef MUX_SOMADOR_REGISTRADOR_COUT_EN
  logic         cout;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_res = 0;
  int exp_cout = 0;

  mux_somador_registrador #(.WIDTH(W)) dut (
    .CLK    (clk),
    .RESET  (rst),
    .A      (a),
    .B      (b),
    .C      (c),
    .S      (s),
    .ENABLE (en),
`ifdef MUX_SOMADOR_REGISTRADOR_COUT_EN
    .COUT   (cout),
`endif
    .RES    (res)
  );

  always #5 clk = ~clk;

  // Reference: unsigned sum of A and the chosen operand, before any wrapping.
  function automatic int full_sum(input int ai, input int bi, input int ci, input int si);
    return ai + ((si != 0) ? bi : ci);
  endfunction

  task automatic set_in(input int ai, input int bi, input int ci, input logic si, input logic ei);
    a  = ai[W-1:0];
    b  = bi[W-1:0];
    c  = ci[W-1:0];
    s  = si;
    en = ei;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(9, 0, 4, 1'b0, 1'b1);
    step();
    step();
    n_cmp++;
    if (res !== 4'd0) begin n_err++; $display("FAIL reset_initial res=%0d expected=0", res); end
    rst = 1'b0;
    step();
    n_cmp++;
    if (res !== 4'd13) begin n_err++; $display("FAIL reset_preload res=%0d expected=13", res); end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (res !== 4'd0) begin n_err++; $display("FAIL reset_async res=%0d expected=0", res); end
    step();
    n_cmp++;
    if (res !== 4'd0) begin n_err++; $display("FAIL reset_held res=%0d expected=0", res); end
`ifdef MUX_SOMADOR_REGISTRADOR_COUT_EN
    n_cmp++;
    if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout cout=%0b expected=0", cout); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_select_b();
    int av[3] = '{0, 10, 1};
    int ev[3] = '{1, 11, 2};
    for (int i = 0; i < 3; i++) begin
      set_in(av[i], 1, 5, 1'b1, 1'b1);
      step();
      n_cmp++;
      if (res !== ev[i][W-1:0]) begin
        n_err++; $display("FAIL select_b[%0d] res=%0d expected=%0d", i, res, ev[i]);
      end
    end
  endtask

  task automatic test_hold();
    set_in(2, 1, 5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (res !== 4'd2) begin n_err++; $display("FAIL hold[%0d] res=%0d expected=2", i, res); end
    end
    s = 1'bx;
    a = 4'd9;
    step();
    n_cmp++;
    if (res !== 4'd2) begin n_err++; $display("FAIL hold_x_sel res=%0d expected=2", res); end
  endtask

  task automatic test_select_c();
    set_in(2, 1, 5, 1'b0, 1'b1);
    step();
    n_cmp++;
    if (res !== 4'd7) begin n_err++; $display("FAIL select_c res=%0d expected=7", res); end
  endtask

  task automatic test_wrap();
    set_in(15, 1, 5, 1'b1, 1'b1);
    step();
    n_cmp++;
    if (res !== 4'd0) begin n_err++; $display("FAIL wrap res=%0d expected=0", res); end
`ifdef MUX_SOMADOR_REGISTRADOR_COUT_EN
    n_cmp++;
    if (cout !== 1'b1) begin n_err++; $display("FAIL wrap_cout cout=%0b expected=1", cout); end
`endif
    a = 4'd3;
    step();
    n_cmp++;
    if (res !== 4'd4) begin n_err++; $display("FAIL post_wrap res=%0d expected=4", res); end
`ifdef MUX_SOMADOR_REGISTRADOR_COUT_EN
    n_cmp++;
    if (cout !== 1'b0) begin n_err++; $display("FAIL post_wrap_cout cout=%0b expected=0", cout); end
`endif
  endtask

  task automatic test_async_priority();
    set_in(6, 3, 0, 1'b1, 1'b1);
    step();
    n_cmp++;
    if (res !== 4'd9) begin n_err++; $display("FAIL async_preload res=%0d expected=9", res); end
    #4 rst = 1'b1;
    #1;
    n_cmp++;
    if (res !== 4'd0) begin n_err++; $display("FAIL async_clear res=%0d expected=0", res); end
    #1 rst = 1'b0;
    set_in(5, 3, 8, 1'b0, 1'b1);
    step();
    n_cmp++;
    if (res !== 4'd13) begin n_err++; $display("FAIL async_reload res=%0d expected=13", res); end
    exp_res  = 13;
    exp_cout = 0;
  endtask

  task automatic test_random();
    int ai, bi, ci, si, ei, fs;
    for (int i = 0; i < 300; i++) begin
      ai = $urandom_range(0, MOD - 1);
      bi = $urandom_range(0, MOD - 1);
      ci = $urandom_range(0, MOD - 1);
      si = $urandom_range(0, 1);
      ei = ($urandom_range(0, 3) != 0) ? 1 : 0;
      set_in(ai, bi, ci, si[0], ei[0]);
      if (ei != 0) begin
        fs       = full_sum(ai, bi, ci, si);
        exp_res  = fs % MOD;
        exp_cout = (fs >= MOD) ? 1 : 0;
      end
      step();
      n_cmp++;
      if (res !== exp_res[W-1:0]) begin
        n_err++; $display("FAIL random[%0d] res=%0d expected=%0d", i, res, exp_res);
      end
`ifdef MUX_SOMADOR_REGISTRADOR_COUT_EN
      n_cmp++;
      if (cout !== exp_cout[0]) begin
        n_err++; $display("FAIL random_cout[%0d] cout=%0b expected=%0d", i, cout, exp_cout);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 1'b0, 1'b0);
    test_reset();
    test_select_b();
    test_hold();
    test_select_c();
    test_wrap();
    test_async_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
